// File: rtl/uart_bus_master.sv
// UART command-frame loader: receives read/write frames on rx, issues one
// data-memory bus access per frame and answers on tx.
`timescale 1ns/1ps
module uart_bus_master #(
    parameter int BAUD_DIV    = 86,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              tx,
    output logic [ADDR_W-1:0] m_r_addr_o,
    output logic [ADDR_W-1:0] m_w_addr_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_r_enable_o,
    output logic              m_w_enable_o,
    input  logic [DATA_W-1:0] m_data_i,
    output logic              busy_o,
    output logic              frame_err_o
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_e;
    typedef enum logic [2:0] {
        S_CMD, S_ADDR, S_WDATA, S_BUS_W, S_BUS_R, S_RCAP, S_REPLY
    } st_e;

    logic rx_s1_q, rx_s2_q, rx_s3_q;

    rx_st_e        rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_vld_q, rx_vld_d;
    logic          rx_err_q, rx_err_d;

    st_e               st_q, st_d;
    logic              op_rd_q, op_rd_d;
    logic [1:0]        nb_q, nb_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [ADDR_W-1:0] m_r_addr_q, m_r_addr_d;
    logic [ADDR_W-1:0] m_w_addr_q, m_w_addr_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_r_en_q, m_r_en_d;
    logic              m_w_en_q, m_w_en_d;
    logic              busy_q, busy_d;
    logic              ferr_q, ferr_d;
    logic              tx_q, tx_d;
    logic [8:0]        tx_sh_q, tx_sh_d;
    logic [3:0]        tx_bits_q, tx_bits_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [31:0]       rep_q, rep_d;
    logic [1:0]        rep_n_q, rep_n_d;

    logic        rep_go, abort;
    logic [31:0] rep_word, addr_nx, wdat_nx;
    logic [1:0]  rep_more;

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q + 1'b1;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_vld_d = 1'b0;
        rx_err_d = 1'b0;
        unique case (rx_st_q)
            R_IDLE: begin
                rx_cnt_d = '0;
                if (rx_s3_q && !rx_s2_q) rx_st_d = R_START;
            end
            R_START: begin
                // a start bit that is high again at mid-bit is a glitch
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_st_d  = rx_s2_q ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_st_d = R_STOP;
                end
            end
            R_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d = '0;
                    rx_vld_d = rx_s2_q;
                    rx_err_d = !rx_s2_q;
                    rx_st_d  = R_IDLE;
                end
            end
            default: rx_st_d = R_IDLE;
        endcase
    end

    always_comb begin
        st_d       = st_q;
        op_rd_d    = op_rd_q;
        nb_d       = nb_q;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        tmo_d      = tmo_q + 1'b1;
        m_r_addr_d = m_r_addr_q;
        m_w_addr_d = m_w_addr_q;
        m_data_d   = m_data_q;
        m_r_en_d   = 1'b0;
        m_w_en_d   = 1'b0;
        busy_d     = busy_q;
        ferr_d     = 1'b0;
        tx_d       = tx_q;
        tx_sh_d    = tx_sh_q;
        tx_bits_d  = tx_bits_q;
        tx_cnt_d   = tx_cnt_q;
        rep_d      = rep_q;
        rep_n_d    = rep_n_q;
        rep_go     = 1'b0;
        rep_word   = '0;
        rep_more   = '0;
        abort      = 1'b0;
        addr_nx    = {addr_q[23:0], rx_sh_q};
        wdat_nx    = {wdat_q[23:0], rx_sh_q};
        unique case (st_q)
            S_CMD: begin
                if (rx_err_q) begin
                    abort = 1'b1;
                end else if (rx_vld_q) begin
                    busy_d = 1'b1;
                    if (rx_sh_q == 8'h57 || rx_sh_q == 8'h52) begin
                        op_rd_d = (rx_sh_q == 8'h52);
                        nb_d    = '0;
                        tmo_d   = '0;
                        st_d    = S_ADDR;
                    end else begin
                        rep_go   = 1'b1;
                        rep_word = {8'h3F, 24'h0};
                    end
                end
            end
            S_ADDR: begin
                if (rx_err_q) begin
                    abort = 1'b1;
                end else if (rx_vld_q) begin
                    addr_d = addr_nx;
                    tmo_d  = '0;
                    nb_d   = nb_q + 1'b1;
                    if (nb_q == 2'd3) begin
                        if (op_rd_q) begin
                            st_d       = S_BUS_R;
                            m_r_en_d   = 1'b1;
                            m_r_addr_d = ADDR_W'(addr_nx);
                        end else begin
                            st_d = S_WDATA;
                        end
                    end
                end else if (tmo_q == TMO_END) begin
                    abort = 1'b1;
                end
            end
            S_WDATA: begin
                if (rx_err_q) begin
                    abort = 1'b1;
                end else if (rx_vld_q) begin
                    wdat_d = wdat_nx;
                    tmo_d  = '0;
                    nb_d   = nb_q + 1'b1;
                    if (nb_q == 2'd3) begin
                        st_d       = S_BUS_W;
                        m_w_en_d   = 1'b1;
                        m_w_addr_d = ADDR_W'(addr_q);
                        m_data_d   = DATA_W'(wdat_nx);
                    end
                end else if (tmo_q == TMO_END) begin
                    abort = 1'b1;
                end
            end
            S_BUS_W: begin
                rep_go   = 1'b1;
                rep_word = {8'h4B, 24'h0};
            end
            S_BUS_R: st_d = S_RCAP;
            S_RCAP: begin
                rep_go   = 1'b1;
                rep_word = 32'(m_data_i);
                rep_more = 2'd3;
            end
            S_REPLY: begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    if (tx_bits_q != 4'd0) begin
                        tx_d      = tx_sh_q[0];
                        tx_sh_d   = {1'b1, tx_sh_q[8:1]};
                        tx_bits_d = tx_bits_q - 1'b1;
                    end else if (rep_n_q != 2'd0) begin
                        // next start bit follows the stop bit directly
                        tx_d      = 1'b0;
                        tx_sh_d   = {1'b1, rep_q[31:24]};
                        rep_d     = {rep_q[23:0], 8'h0};
                        rep_n_d   = rep_n_q - 1'b1;
                        tx_bits_d = 4'd9;
                    end else begin
                        st_d   = S_CMD;
                        busy_d = 1'b0;
                    end
                end
            end
            default: st_d = S_CMD;
        endcase
        if (rep_go) begin
            st_d      = S_REPLY;
            tx_d      = 1'b0;
            tx_sh_d   = {1'b1, rep_word[31:24]};
            rep_d     = {rep_word[23:0], 8'h0};
            rep_n_d   = rep_more;
            tx_bits_d = 4'd9;
            tx_cnt_d  = '0;
        end
        if (abort) begin
            ferr_d = 1'b1;
            busy_d = 1'b0;
            st_d   = S_CMD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_st_q    <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_vld_q   <= 1'b0;
            rx_err_q   <= 1'b0;
            st_q       <= S_CMD;
            op_rd_q    <= 1'b0;
            nb_q       <= '0;
            addr_q     <= '0;
            wdat_q     <= '0;
            tmo_q      <= '0;
            m_r_addr_q <= '0;
            m_w_addr_q <= '0;
            m_data_q   <= '0;
            m_r_en_q   <= 1'b0;
            m_w_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            ferr_q     <= 1'b0;
            tx_q       <= 1'b1;
            tx_sh_q    <= '1;
            tx_bits_q  <= '0;
            tx_cnt_q   <= '0;
            rep_q      <= '0;
            rep_n_q    <= '0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_vld_q   <= rx_vld_d;
            rx_err_q   <= rx_err_d;
            st_q       <= st_d;
            op_rd_q    <= op_rd_d;
            nb_q       <= nb_d;
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
            tmo_q      <= tmo_d;
            m_r_addr_q <= m_r_addr_d;
            m_w_addr_q <= m_w_addr_d;
            m_data_q   <= m_data_d;
            m_r_en_q   <= m_r_en_d;
            m_w_en_q   <= m_w_en_d;
            busy_q     <= busy_d;
            ferr_q     <= ferr_d;
            tx_q       <= tx_d;
            tx_sh_q    <= tx_sh_d;
            tx_bits_q  <= tx_bits_d;
            tx_cnt_q   <= tx_cnt_d;
            rep_q      <= rep_d;
            rep_n_q    <= rep_n_d;
        end
    end

    assign tx           = tx_q;
    assign m_r_addr_o   = m_r_addr_q;
    assign m_w_addr_o   = m_w_addr_q;
    assign m_data_o     = m_data_q;
    assign m_r_enable_o = m_r_en_q;
    assign m_w_enable_o = m_w_en_q;
    assign busy_o       = busy_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed + randomized bench for uart_bus_master with a frame-level
// reference model, a bus responder and a tx byte decoder.
`timescale 1ns/1ps
module tb_uart_bus_master;

    localparam int BD  = 8;
    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst_n, rx, tx;
    logic [31:0] m_r_addr_o, m_w_addr_o, m_data_o, m_data_i;
    logic        m_r_enable_o, m_w_enable_o, busy_o, frame_err_o;

    uart_bus_master #(
        .BAUD_DIV(BD), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx),
        .m_r_addr_o(m_r_addr_o), .m_w_addr_o(m_w_addr_o),
        .m_data_o(m_data_o), .m_r_enable_o(m_r_enable_o),
        .m_w_enable_o(m_w_enable_o), .m_data_i(m_data_i),
        .busy_o(busy_o), .frame_err_o(frame_err_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int wr_cnt = 0, rd_cnt = 0, ferr_cnt = 0, overlap = 0, tx_falls = 0;
    int s_w, s_r, s_e, s_f;
    logic [31:0] last_waddr, last_wdata, last_raddr;
    logic [31:0] rd_val = 32'h0, ra, rdat;
    logic        rd_seen = 1'b0;
    logic [7:0]  rxq[$];
    logic        stq[$];
    time         starts[$];
    logic        dec_abort = 1'b0;
    logic [7:0]  dec_b, ub;
    time         dec_t0;
    logic [7:0]  frm[$];
    logic [7:0]  exp_rep[$];
    int          exp_w, exp_r;
    logic [31:0] exp_addr, exp_data;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_w_enable_o) begin
            wr_cnt++;
            last_waddr = m_w_addr_o;
            last_wdata = m_data_o;
        end
        if (m_r_enable_o) begin
            rd_cnt++;
            last_raddr = m_r_addr_o;
        end
        if (m_w_enable_o && m_r_enable_o) overlap++;
        if (frame_err_o) ferr_cnt++;
    end

    // responder: data valid only in the cycle after the read strobe
    always @(posedge clk) begin
        #1;
        m_data_i = rd_seen ? rd_val : $urandom();
        rd_seen  = m_r_enable_o;
    end

    always @(negedge tx) tx_falls++;
    always @(negedge rst_n) dec_abort = 1'b1;

    always begin
        @(negedge tx);
        if (rst_n === 1'b1) begin
            dec_t0    = $time;
            dec_abort = 1'b0;
            repeat (BD / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BD) @(posedge clk);
                #1 dec_b[i] = tx;
            end
            repeat (BD) @(posedge clk);
            #1;
            if (!dec_abort) begin
                rxq.push_back(dec_b);
                stq.push_back(tx);
                starts.push_back(dec_t0);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic bad_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BD) @(negedge clk);
        end
        rx = ~bad_stop;
        repeat (BD) @(negedge clk);
        rx = 1'b1;
    endtask

    // frame-level expectations from the command byte layout
    task automatic model_frame();
        exp_rep.delete();
        exp_w = 0;
        exp_r = 0;
        exp_addr = 32'h0;
        exp_data = 32'h0;
        if (frm.size() == 9 && frm[0] == 8'h57) begin
            exp_w    = 1;
            exp_addr = {frm[1], frm[2], frm[3], frm[4]};
            exp_data = {frm[5], frm[6], frm[7], frm[8]};
            exp_rep.push_back(8'h4B);
        end else if (frm.size() == 5 && frm[0] == 8'h52) begin
            exp_r    = 1;
            exp_addr = {frm[1], frm[2], frm[3], frm[4]};
            for (int i = 3; i >= 0; i--) exp_rep.push_back(rd_val[8*i +: 8]);
        end else begin
            exp_rep.push_back(8'h3F);
        end
    endtask

    task automatic run_frame(input string tag);
        int w0, r0, e0;
        model_frame();
        w0 = wr_cnt;
        r0 = rd_cnt;
        e0 = ferr_cnt;
        rxq.delete();
        stq.delete();
        starts.delete();
        foreach (frm[i]) begin
            send_byte(frm[i], 1'b0);
            if (i == 0) check({tag, " busy_mid"}, 32'(busy_o), 1);
        end
        for (int c = 0; c < 3000 && rxq.size() < exp_rep.size(); c++)
            @(negedge clk);
        check({tag, " reply_len"}, rxq.size(), exp_rep.size());
        check({tag, " busy_at_stop"}, 32'(busy_o), 1);
        for (int c = 0; c < 2 * BD && busy_o !== 1'b0; c++) @(negedge clk);
        check({tag, " busy_done"}, 32'(busy_o), 0);
        check({tag, " wr_strobes"}, wr_cnt - w0, exp_w);
        check({tag, " rd_strobes"}, rd_cnt - r0, exp_r);
        check({tag, " frame_err"}, ferr_cnt - e0, 0);
        check({tag, " overlap"}, overlap, 0);
        if (exp_w != 0) begin
            check({tag, " waddr"}, last_waddr, exp_addr);
            check({tag, " wdata"}, last_wdata, exp_data);
        end
        if (exp_r != 0) check({tag, " raddr"}, last_raddr, exp_addr);
        foreach (exp_rep[i]) begin
            if (i < rxq.size()) begin
                check({tag, " tx_byte"}, 32'(rxq[i]), 32'(exp_rep[i]));
                check({tag, " tx_stop"}, 32'(stq[i]), 1);
            end
        end
        for (int i = 1; i < starts.size(); i++)
            check({tag, " tx_gap"}, 32'(starts[i] - starts[i-1]), BD * 100);
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst tx", 32'(tx), 1);
        check("rst busy", 32'(busy_o), 0);
        check("rst ferr", 32'(frame_err_o), 0);
        check("rst wen", 32'(m_w_enable_o), 0);
        check("rst ren", 32'(m_r_enable_o), 0);
        check("rst raddr", m_r_addr_o, 0);
        check("rst waddr", m_w_addr_o, 0);
        check("rst wdata", m_data_o, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        frm = '{8'h57, 8'h00, 8'h00, 8'h10, 8'h00,
                8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame("wr0");

        rd_val = 32'h12345678;
        frm = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h00};
        run_frame("rd0");

        frm = '{8'hA5};
        run_frame("unk");
        ra   = $urandom();
        rdat = $urandom();
        frm = '{8'h57, ra[31:24], ra[23:16], ra[15:8], ra[7:0],
                rdat[31:24], rdat[23:16], rdat[15:8], rdat[7:0]};
        run_frame("unk_wr");

        s_w = wr_cnt;
        s_r = rd_cnt;
        s_e = ferr_cnt;
        rxq.delete();
        send_byte(8'h57, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check("tmo busy_mid", 32'(busy_o), 1);
        repeat (250) @(negedge clk);
        check("tmo ferr", ferr_cnt - s_e, 1);
        check("tmo wr", wr_cnt - s_w, 0);
        check("tmo rd", rd_cnt - s_r, 0);
        check("tmo busy", 32'(busy_o), 0);
        check("tmo tx", rxq.size(), 0);
        rd_val = $urandom();
        ra     = $urandom();
        frm = '{8'h52, ra[31:24], ra[23:16], ra[15:8], ra[7:0]};
        run_frame("tmo_rd");

        s_e = ferr_cnt;
        rxq.delete();
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch ferr", ferr_cnt - s_e, 0);
        check("glitch busy", 32'(busy_o), 0);
        check("glitch tx", rxq.size(), 0);

        s_r = rd_cnt;
        send_byte(8'h52, 1'b1);
        repeat (20) @(negedge clk);
        check("stop ferr", ferr_cnt - s_e, 1);
        check("stop busy", 32'(busy_o), 0);
        check("stop rd", rd_cnt - s_r, 0);
        check("stop tx", rxq.size(), 0);
        ra   = $urandom();
        rdat = $urandom();
        frm = '{8'h57, ra[31:24], ra[23:16], ra[15:8], ra[7:0],
                rdat[31:24], rdat[23:16], rdat[15:8], rdat[7:0]};
        run_frame("stop_wr");

        for (int k = 0; k < 3; k++) begin
            ra   = $urandom();
            rdat = $urandom();
            frm = '{8'h57, ra[31:24], ra[23:16], ra[15:8], ra[7:0],
                    rdat[31:24], rdat[23:16], rdat[15:8], rdat[7:0]};
            run_frame("rnd_wr");
            rd_val = $urandom();
            ra     = $urandom();
            frm = '{8'h52, ra[31:24], ra[23:16], ra[15:8], ra[7:0]};
            run_frame("rnd_rd");
            do ub = 8'($urandom_range(0, 255));
            while (ub == 8'h57 || ub == 8'h52);
            frm = '{ub};
            run_frame("rnd_unk");
        end

        rd_val = 32'h12345678;
        frm = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h00};
        rxq.delete();
        foreach (frm[i]) send_byte(frm[i], 1'b0);
        for (int c = 0; c < 3000 && rxq.size() < 1; c++) @(negedge clk);
        for (int c = 0; c < 4 * BD && tx !== 1'b0; c++) @(negedge clk);
        @(negedge clk);
        check("rst_mid pre_tx", 32'(tx), 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid tx", 32'(tx), 1);
        check("rst_mid busy", 32'(busy_o), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        s_f = tx_falls;
        s_r = rd_cnt;
        repeat (300) @(negedge clk);
        check("rst_mid quiet", tx_falls - s_f, 0);
        check("rst_mid tx_idle", 32'(tx), 1);
        check("rst_mid busy_idle", 32'(busy_o), 0);
        check("rst_mid rd", rd_cnt - s_r, 0);
        ra   = $urandom();
        rdat = $urandom();
        frm = '{8'h57, ra[31:24], ra[23:16], ra[15:8], ra[7:0],
                rdat[31:24], rdat[23:16], rdat[15:8], rdat[7:0]};
        run_frame("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- UART-driven memory-bus initiator, used as a debug/program loader for the core.
- Receives command frames on rx and issues single-word reads/writes on the data-memory bus, driving the same address/data/enable signal set the bus peripherals respond to. Responders return read data one cycle after the read enable.
- Returns an acknowledge byte or the read data on tx.
- Baud rate is fixed by parameter; there is no register interface.

Parameters:
- BAUD_DIV, 86, clock cycles per bit (10 MHz / 115200); minimum 4.
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width; fixed at 32 by the frame format.
- TIMEOUT_CYC, 100000, maximum idle cycles between bytes of one frame.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  serial input, idle high, asynchronous to clk
- tx  out  1  serial output, idle high
- m_r_addr_o  out  ADDR_W  bus read address
- m_w_addr_o  out  ADDR_W  bus write address
- m_data_o  out  DATA_W  bus write data
- m_r_enable_o  out  1  bus read strobe, one-cycle pulse
- m_w_enable_o  out  1  bus write strobe, one-cycle pulse
- m_data_i  in  DATA_W  bus read data, valid the cycle after m_r_enable_o
- busy_o  out  1  high from first byte of a frame until reply fully sent
- frame_err_o  out  1  one-cycle pulse on an rx stop-bit error or a frame timeout

Behaviour:
- Reset is asynchronous active-low: one clock, reset asserted on rst_n low at any time.
  - Reset values: tx=1, all m_* outputs 0, busy_o=0, frame_err_o=0.
  - All FSMs go to IDLE and any partial frame or reply is dropped.
  - tx returns high immediately, even mid-byte.
- Serial format: 8N1, LSB first, bit period exactly BAUD_DIV cycles.
- RX engine:
  - rx passes through a 2-flop synchronizer, reset value 1.
  - A start bit is detected on a synchronized falling edge while idle.
  - The start bit is re-checked at BAUD_DIV/2 (integer division); if it is high, it is a glitch and the engine returns to idle silently.
  - Data bits are sampled every BAUD_DIV cycles thereafter.
  - Stop bit: if sampled 1, a one-cycle byte_valid is produced. If sampled 0, frame_err_o pulses, the byte is discarded and the command FSM returns to CMD.
- Frame format (multi-byte fields MSB first):
  - Write: 0x57, A3..A0, D3..D0.
  - Read: 0x52, A3..A0.
- Command FSM states: CMD, ADDR, WDATA, BUS_W, BUS_R, RCAP, REPLY.
  - CMD: on 0x57 or 0x52, latch the opcode and go to ADDR (byte count cleared, busy_o=1). On any other byte, queue reply 0x3F ('?') and go to REPLY.
  - ADDR: shift in 4 bytes. After the 4th byte, go to WDATA for a write or BUS_R for a read.
  - WDATA: shift in 4 bytes, then go to BUS_W.
  - BUS_W: one cycle with m_w_enable_o=1, m_w_addr_o=address, m_data_o=data. Queue reply 0x4B ('K') and go to REPLY.
  - BUS_R: one cycle with m_r_enable_o=1, m_r_addr_o=address; go to RCAP.
  - RCAP: capture m_data_i, queue 4 bytes MSB first, go to REPLY.
  - REPLY: the TX engine sends the queued bytes back to back (stop bit of one byte immediately followed by the next start bit). After the last stop bit ends: busy_o=0, return to CMD.
- Address/data/enable outputs:
  - m_*_addr_o and m_data_o hold their values between strobes; they are only updated when a strobe is issued.
  - The enables are never high simultaneously and are never high outside BUS_W/BUS_R.
- Timeout:
  - In ADDR or WDATA, a counter clears on each received byte.
  - Reaching TIMEOUT_CYC gives a frame_err_o pulse, drops the frame, returns to CMD and sets busy_o=0.
  - No bus access is issued for a truncated frame.
- Bytes received during REPLY are discarded and no error is signalled.
- Latency, last rx stop-bit sample to tx start bit: at most 4 cycles.

Test Plan:
- BAUD_DIV=8. Send 57 00 00 10 00 DE AD BE EF. Expect exactly one m_w_enable_o pulse with m_w_addr_o=0x00001000 and m_data_o=0xDEADBEEF, then tx byte 0x4B, and busy_o low after its stop bit.
- Send 52 00 00 10 00 with the bus model returning 0x12345678 one cycle after m_r_enable_o. Expect one read pulse at address 0x1000, then tx bytes 12 34 56 78 back to back with no idle gap.
- Send 0xA5. Expect tx 0x3F, no bus strobes, and the FSM back in CMD, proven by a following valid write succeeding.
- TIMEOUT_CYC=200. Send 57 00 00 then idle 250 cycles. Expect a frame_err_o pulse, no strobe, and busy_o=0. A subsequent full read frame completes normally.
- Send a byte with its stop bit forced 0. Expect a frame_err_o pulse and the byte dropped. Separately, a 2-cycle low glitch on rx is ignored.
- Assert rst_n low mid-way through a read reply. Expect tx=1 and busy_o=0 asynchronously, and no further tx activity after release.
